// File: rtl/enc_sched.sv
// enc_sched: round-robin scheduler sharing one fully pipelined AES-128 encryptor
// between NREQ requesters. Issues at most one block per cycle, tracks the owner of
// each in-flight block in a tag pipe matched to the encryptor latency, and steers
// each ciphertext into a per-requester response FIFO. Per-requester credits bound
// in-flight + queued blocks to BUF_DEPTH, so a FIFO can never overflow even though
// the encryptor has no backpressure.
//
// Optional build macro ENC_SCHED_STATS_EN adds done_cnt: per-requester 16-bit
// saturating completion counters.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (ready is one-hot or zero)
//   req_pt/req_key       128-bit plaintext/key per requester, requester i at [128*i +: 128]
//   enc_pt/enc_key       registered block to the encryptor
//   enc_enable           issue strobe, one cycle after the grant
//   enc_ct/enc_valid     ciphertext returning from the encryptor
//   rsp_valid/rsp_ready  per-requester FIFO non-empty / pop
//   rsp_ct               FIFO head per requester (zero when empty)
//   err                  sticky flag: tag pipe and enc_valid disagreed
//   done_cnt             (ENC_SCHED_STATS_EN only) completion counters, 16 bits each
module enc_sched #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned ENC_LATENCY = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [128*NREQ-1:0] req_pt,
  input  logic [128*NREQ-1:0] req_key,
  output logic [127:0]        enc_pt,
  output logic [127:0]        enc_key,
  output logic                enc_enable,
  input  logic [127:0]        enc_ct,
  input  logic                enc_valid,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [128*NREQ-1:0] rsp_ct,
  output logic                err
`ifdef ENC_SCHED_STATS_EN
  ,
  output logic [16*NREQ-1:0]  done_cnt
`endif
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AddrW = $clog2(BUF_DEPTH);
  localparam int unsigned CredW = AddrW + 1;
  localparam int unsigned CntW  = $clog2(ENC_LATENCY + 2);
  localparam logic [CntW-1:0] DrainInit = CntW'(ENC_LATENCY + 1);

  // ---------------------------------------------------------------------------
  // Drain FSM: the encryptor has no reset, so its output is ignored until
  // everything issued before reset has flushed out.
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StDrain, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic            run;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      StDrain: begin
        if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q <= CntW'(1)) state_d = StRun;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDrain;
      drain_cnt_q <= DrainInit;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign run = (state_q == StRun);

  // ---------------------------------------------------------------------------
  // Round-robin arbitration over requesters holding a credit
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0][CredW-1:0] credit_q, credit_d;
  logic [NREQ-1:0]            eligible, grant_oh, pop, push;
  logic                       grant_vld;
  logic [IdxW-1:0]            grant_idx, cand, ptr_q, ptr_d;
  logic [127:0]               sel_pt, sel_key;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = run && req_valid[i] && (credit_q[i] != '0);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = (cand == IdxW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    sel_pt  = '0;
    sel_key = '0;
    if (grant_vld) ptr_d = (grant_idx == IdxW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == IdxW'(i));
      if (grant_oh[i]) begin
        sel_pt  = req_pt[128*i +: 128];
        sel_key = req_key[128*i +: 128];
      end
    end
  end

  assign req_ready = grant_oh;

  // ---------------------------------------------------------------------------
  // Issue registers and tag pipe
  // ---------------------------------------------------------------------------
  logic                             issue_q;
  logic [IdxW-1:0]                  tag_q;
  logic [127:0]                     pt_q, key_q;
  logic [ENC_LATENCY-1:0]           pipe_vld_q;
  logic [ENC_LATENCY-1:0][IdxW-1:0] pipe_idx_q;
  logic                             tail_vld;
  logic [IdxW-1:0]                  tail_idx;
  logic                             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q    <= 1'b0;
      tag_q      <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      issue_q    <= grant_vld;
      ptr_q      <= ptr_d;
      if (grant_vld) begin
        tag_q <= grant_idx;
        pt_q  <= sel_pt;
        key_q <= sel_key;
      end
      // Stage 0 lines up with enc_enable, so the tail lines up with enc_valid.
      pipe_vld_q <= {pipe_vld_q[ENC_LATENCY-2:0], issue_q};
      pipe_idx_q <= {pipe_idx_q[ENC_LATENCY-2:0], tag_q};
      if (run && (tail_vld != enc_valid)) err_q <= 1'b1;
    end
  end

  assign enc_enable = issue_q;
  assign enc_pt     = pt_q;
  assign enc_key    = key_q;
  assign err        = err_q;
  assign tail_vld   = pipe_vld_q[ENC_LATENCY-1];
  assign tail_idx   = pipe_idx_q[ENC_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Credits: one per free FIFO slot not already claimed by an in-flight block
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    for (int i = 0; i < NREQ; i++) begin
      case ({grant_oh[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - 1'b1;
        2'b01:   credit_d[i] = credit_q[i] + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= {NREQ{CredW'(BUF_DEPTH)}};
    else        credit_q <= credit_d;
  end

  // ---------------------------------------------------------------------------
  // Response FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    logic [127:0]   mem [BUF_DEPTH];
    logic [AddrW:0] wr_q, rd_q;
    logic           empty;

    assign push[i]              = run && tail_vld && enc_valid && (tail_idx == IdxW'(i));
    assign empty                = (wr_q == rd_q);
    assign rsp_valid[i]         = !empty;
    assign pop[i]               = rsp_valid[i] && rsp_ready[i];
    assign rsp_ct[128*i +: 128] = empty ? '0 : mem[rd_q[AddrW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push[i]) wr_q <= wr_q + 1'b1;
        if (pop[i])  rd_q <= rd_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_q[AddrW-1:0]] <= enc_ct;
    end
  end

`ifdef ENC_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i] && (done_q[i] != 16'hFFFF)) done_q[i] <= done_q[i] + 16'd1;
      end
    end
  end

  assign done_cnt = done_q;
`endif

endmodule

// File: tb/tb_enc_sched.sv
// Testbench for enc_sched. Contains a stub encryptor with the same latency contract
// as the real core (exact AES answer for the FIPS-197 vector, a simple keyed mix for
// everything else) and a per-requester scoreboard of expected ciphertexts.
module tb_enc_sched;
  localparam int unsigned NREQ = 2;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned LAT = 10;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [128*NREQ-1:0] req_pt = '0;
  logic [128*NREQ-1:0] req_key = '0;
  logic [127:0]        enc_pt, enc_key, enc_ct;
  logic                enc_enable, enc_valid;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '0;
  logic [128*NREQ-1:0] rsp_ct;
  logic                err;
`ifdef ENC_SCHED_STATS_EN
  logic [16*NREQ-1:0]  done_cnt;
`endif

  always #5 clk = ~clk;

  enc_sched #(
    .NREQ        (NREQ),
    .BUF_DEPTH   (BUF_DEPTH),
    .ENC_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pt     (req_pt),
    .req_key    (req_key),
    .enc_pt     (enc_pt),
    .enc_key    (enc_key),
    .enc_enable (enc_enable),
    .enc_ct     (enc_ct),
    .enc_valid  (enc_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_ct     (rsp_ct),
`ifdef ENC_SCHED_STATS_EN
    .done_cnt   (done_cnt),
`endif
    .err        (err)
  );

  function automatic logic [127:0] enc_f(input logic [127:0] pt, input logic [127:0] key);
    if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stub encryptor: captures pt/key while enable is high, answers LAT cycles later.
  logic              noise_en = 1'b0;
  logic              noise_bit = 1'b0;
  logic              force_hi = 1'b0;
  logic [LAT-1:0]    m_vld = '0;
  logic [127:0]      m_ct [LAT];

  always @(posedge clk) begin
    m_vld    <= {m_vld[LAT-2:0], enc_enable};
    m_ct[0]  <= enc_f(enc_pt, enc_key);
    for (int k = 1; k < LAT; k++) m_ct[k] <= m_ct[k-1];
  end

  assign enc_valid = noise_en ? noise_bit : (force_hi | m_vld[LAT-1]);
  assign enc_ct    = m_ct[LAT-1];

  // Checking and scoreboard state
  int n_checks = 0;
  int n_errs = 0;

  logic [127:0]    exp0[$];
  logic [127:0]    exp1[$];
  int              gcnt [NREQ];
  int              last_grant = -1;
  logic            alt_mode = 1'b0;
  logic            prev_vld = 1'b0;
  logic [127:0]    prev_pt = '0;
  logic [127:0]    prev_key = '0;
  logic [NREQ-1:0] s_ready, s_rsp_valid;
  logic            s_err, s_enable;
  logic [127:0]    s_rsp_ct0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [127:0] e;
    s_ready     = req_ready;
    s_rsp_valid = rsp_valid;
    s_err       = err;
    s_enable    = enc_enable;
    s_rsp_ct0   = rsp_ct[127:0];
    check_eq("ready_onehot0", 128'($onehot0(req_ready)), 128'd1);
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      check_eq("enc_enable", 128'(enc_enable), 128'(prev_vld));
      if (prev_vld) begin
        check_eq("enc_pt", enc_pt, prev_pt);
        check_eq("enc_key", enc_key, prev_key);
      end
    end
    prev_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        prev_vld = 1'b1;
        prev_pt  = req_pt[128*i +: 128];
        prev_key = req_key[128*i +: 128];
        if (i == 0) exp0.push_back(enc_f(prev_pt, prev_key));
        else        exp1.push_back(enc_f(prev_pt, prev_key));
        gcnt[i]++;
        if (alt_mode && last_grant >= 0) check_eq("rr_alternate", 128'(i), 128'(1 - last_grant));
        last_grant = i;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
          check_eq($sformatf("rsp%0d_spurious", i), 128'(rsp_valid[i]), 128'd0);
        end else begin
          e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
          check_eq($sformatf("rsp%0d_ct", i), rsp_ct[128*i +: 128], e);
        end
      end
    end
  endtask

  // Starts and ends at a falling edge; samples 1 time unit before the rising edge.
  task automatic tick();
    noise_bit = 1'($urandom_range(0, 1));
    #4;
    monitor();
    @(negedge clk);
  endtask

  task automatic drain_all(input string tag);
    int b;
    b = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && b < 80) begin
      tick();
      b++;
    end
    check_eq({tag, "_sb_empty"}, 128'(exp0.size() + exp1.size()), 128'd0);
    tick();
    check_eq({tag, "_rsp_idle"}, 128'(s_rsp_valid), 128'd0);
  endtask

  initial begin
    int lat;
    int g1;
    int b;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 128'(req_ready), 128'd0);
    check_eq("rst_enc_enable", 128'(enc_enable), 128'd0);
    check_eq("rst_enc_pt", enc_pt, 128'd0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_rsp_ct", 128'(rsp_ct[127:0] | rsp_ct[255:128]), 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);

    // Known-answer block through the drain window
    req_pt[127:0]  = KAT_PT;
    req_key[127:0] = KAT_KEY;
    req_valid      = 2'b01;
    rsp_ready      = 2'b11;
    rst_n          = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      check_eq("drain_no_ready", 128'(s_ready), 128'd0);
    end
    tick();
    check_eq("first_grant", 128'(s_ready), 128'd1);
    req_valid = '0;
    lat = 0;
    while (!s_rsp_valid[0] && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("kat_latency", 128'(lat), 128'd12);
    check_eq("kat_ct", s_rsp_ct0, KAT_CT);
    check_eq("kat_err", 128'(s_err), 128'd0);
    drain_all("kat");

    // Both requesters streaming: alternation and back-to-back issue until credits run out
    alt_mode   = 1'b1;
    last_grant = -1;
    req_valid  = 2'b11;
    for (int t = 0; t < 20; t++) begin
      req_pt  = {rand128(), rand128()};
      req_key = {rand128(), rand128()};
      tick();
      if (t >= 1 && t <= 8) check_eq("burst_enable", 128'(s_enable), 128'd1);
    end
    req_valid = '0;
    alt_mode  = 1'b0;
    drain_all("stream");

    // Credit exhaustion on requester 1
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    g1 = gcnt[1];
    for (int t = 0; t < 30; t++) begin
      req_pt[255:128] = rand128();
      tick();
    end
    check_eq("credit_grants", 128'(gcnt[1] - g1), 128'd4);
    check_eq("credit_ready_low", 128'(s_ready[1]), 128'd0);
    check_eq("credit_fifo_full_valid", 128'(s_rsp_valid[1]), 128'd1);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b01;
    for (int t = 0; t < 20; t++) tick();
    check_eq("credit_one_more", 128'(gcnt[1] - g1), 128'd5);
    req_valid = '0;
    rsp_ready = 2'b11;
    drain_all("credit");

    // Reset with blocks in flight, garbage on enc_valid during the drain
    req_valid = 2'b11;
    for (int t = 0; t < 5; t++) begin
      req_pt  = {rand128(), rand128()};
      req_key = {rand128(), rand128()};
      tick();
    end
    rst_n    = 1'b0;
    noise_en = 1'b1;
    exp0.delete();
    exp1.delete();
    req_valid = 2'b01;
    req_pt[127:0] = rand128();
    tick();
    tick();
    check_eq("midrst_rsp_valid", 128'(s_rsp_valid), 128'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      check_eq("midrst_drain_ready", 128'(s_ready), 128'd0);
      check_eq("midrst_drain_rsp", 128'(s_rsp_valid), 128'd0);
      check_eq("midrst_drain_err", 128'(s_err), 128'd0);
    end
    noise_en = 1'b0;
    tick();
    check_eq("midrst_grant", 128'(s_ready), 128'd1);
    req_valid = '0;
    drain_all("midrst");
    check_eq("midrst_err_final", 128'(err), 128'd0);

    // Spurious enc_valid with nothing outstanding
    force_hi = 1'b1;
    tick();
    force_hi = 1'b0;
    tick();
    check_eq("spur_err_set", 128'(s_err), 128'd1);
    check_eq("spur_no_push", 128'(s_rsp_valid), 128'd0);
    for (int t = 0; t < 3; t++) tick();
    check_eq("spur_err_sticky", 128'(s_err), 128'd1);
    check_eq("spur_no_push_late", 128'(s_rsp_valid), 128'd0);
    rst_n = 1'b0;
    #1;
    check_eq("spur_err_cleared", 128'(err), 128'd0);
    @(negedge clk);

`ifdef ENC_SCHED_STATS_EN
    check_eq("stats_reset", 128'(done_cnt), 128'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    g1 = gcnt[0];
    req_valid = 2'b01;
    b = 0;
    while (gcnt[0] - g1 < 3 && b < 40) begin
      req_pt[127:0] = rand128();
      tick();
      b++;
    end
    g1 = gcnt[1];
    req_valid = 2'b10;
    b = 0;
    while (gcnt[1] - g1 < 1 && b < 40) begin
      tick();
      b++;
    end
    req_valid = '0;
    drain_all("stats");
    check_eq("stats_done_cnt", 128'(done_cnt), 128'({16'd1, 16'd3}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/enc_sched.md
Name: enc_sched

Overview:
Round-robin scheduler that shares one fully pipelined AES-128 encryptor (`enc`) between NREQ requesters.
- Issues at most one block per cycle into the pipeline.
- Tracks each block's requester with a tag shift register aligned to the pipeline latency.
- Steers each ciphertext into a per-requester response FIFO.
- Uses credits so the pipeline, which has no backpressure, can never overflow a FIFO.

Parameters:
NREQ, 2, number of requesters (2..4)
BUF_DEPTH, 4, entries per response FIFO; also the per-requester credit limit (power of 2, ≥2)
ENC_LATENCY, 10, cycles from enc_enable high to the matching enc_valid high

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_pt  in  128*NREQ  plaintexts; requester i uses bits [128*i+127:128*i]
req_key  in  128*NREQ  keys, same packing as req_pt
enc_pt  out  128  plaintext to encryptor
enc_key  out  128  key to encryptor
enc_enable  out  1  issue strobe to encryptor
enc_ct  in  128  ciphertext from encryptor
enc_valid  in  1  ciphertext valid from encryptor
rsp_valid  out  NREQ  response FIFO non-empty
rsp_ready  in  NREQ  response pop
rsp_ct  out  128*NREQ  FIFO head per requester, same packing as req_pt
err  out  1  sticky tag/valid mismatch flag

Behaviour:
- Reset: all outputs 0; FIFOs empty; credits = BUF_DEPTH; RR pointer = 0; tag pipe cleared.
  - State DRAIN is entered on reset. drain_cnt loads ENC_LATENCY+1 and decrements each cycle.
- DRAIN state:
  - req_ready = 0 and enc_enable = 0.
  - enc_valid is ignored (the encryptor has no reset, so stale or X data is flushed here).
  - Transition to RUN when drain_cnt reaches 0.
- RUN arbitration (combinational):
  - Eligible(i) = req_valid[i] && credit[i] != 0.
  - Grant = first eligible index starting at ptr, wrapping modulo NREQ.
  - req_ready[g] = 1 for the granted index only.
  - On a grant, ptr <= g+1 mod NREQ; with no grant, ptr holds.
- Issue timing: the encryptor registers plaintext/key at edge T and needs enable during the following cycle.
  - On a grant at edge T: enc_pt/enc_key <= req_pt[g]/req_key[g], and issue_q <= 1 with tag g.
  - enc_enable = issue_q, registered and driven 1 cycle after the grant.
  - enc_pt/enc_key hold their last value when there is no grant.
  - Sustained throughput: 1 grant per cycle.
- Tag pipe: an ENC_LATENCY-deep shift register of {valid, idx}.
  - Head loads {issue_q, tag_q} each cycle.
  - The tail aligns with enc_valid exactly ENC_LATENCY cycles after enc_enable.
- Completion (RUN only):
  - If tail.valid && enc_valid: push enc_ct into FIFO[tail.idx].
  - If tail.valid != enc_valid: set err (sticky until reset) and push nothing.
- Credits:
  - credit[i] decrements on grant i and increments on a FIFO[i] pop (rsp_valid[i] && rsp_ready[i]).
  - A simultaneous grant and pop on the same i leaves credit unchanged.
  - Invariant: credit + in-flight + occupancy = BUF_DEPTH, so a push can never hit a full FIFO.
- FIFO: circular, log2(BUF_DEPTH)+1 bit pointers.
  - rsp_ct is the head entry, valid when non-empty.
  - Pop and push in the same cycle are allowed at any occupancy, including full.
  - Pop on empty is ignored.
- Reset mid-operation: in-flight blocks and FIFO contents are discarded; DRAIN is re-entered.
- Latency: grant edge to rsp_valid = ENC_LATENCY+2 cycles (FIFO empty, no stall).

Optional Feature:
ENC_SCHED_STATS_EN
- Defined: adds output port done_cnt (16*NREQ): per-requester 16-bit saturating counters (stop at 16'hFFFF), incremented on each FIFO push and cleared by reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Release reset, requester 0 issues key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → req_ready low during the 11 DRAIN cycles; rsp_ct[0] = 69c4e0d86a7b0430d8cdb78070b4c55a exactly 12 cycles after the grant; err = 0.
- Both requesters hold req_valid with rsp_ready = 1 for 20 cycles → grants alternate 0,1,0,1…; enc_enable high every cycle; every response lands in the correct FIFO in issue order.
- Requester 1 requests continuously with rsp_ready[1] = 0 → exactly 4 grants, then req_ready[1] stays 0; raising rsp_ready[1] for 1 cycle → exactly 1 further grant.
- Assert rst_n low with 5 blocks in flight, then release → no rsp_valid and no err during the 11-cycle drain despite X/garbage on enc_valid; a subsequent request completes correctly.
- Bench forces enc_valid high with no tag outstanding → err = 1 from the next cycle, no FIFO push; err stays 1 until reset.
- With ENC_SCHED_STATS_EN defined, 3 completions for requester 0 and 1 for requester 1 → done_cnt = {16'd1, 16'd3}.
